// File: rtl/core_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, the
// register-zero index and the pipeline-enable bundle with its canned patterns.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_MWAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic front_hold;
        logic memwb_bubble;
    } ctrl_t;

    // Field order: pc_write, ifid_write, ifid_flush, idex_flush, front_hold, memwb_bubble
    localparam ctrl_t CTRL_RUN      = ctrl_t'(6'b110000);
    localparam ctrl_t CTRL_FREEZE   = ctrl_t'(6'b000011);
    localparam ctrl_t CTRL_LU       = ctrl_t'(6'b000100);
    localparam ctrl_t CTRL_REDIRECT = ctrl_t'(6'b111100);

endpackage

// File: rtl/hazard_controller_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave): hazard sources in, register enables and counters out.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic             IDEX_mem_read;
    logic [4:0]       IDEX_rd;
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             IFID_use_rs1;
    logic             IFID_use_rs2;
    logic             EX_redirect;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_flush;
    logic             front_hold;
    logic             MEMWB_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output IDEX_mem_read, IDEX_rd, IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
               EX_redirect, dmem_req, dmem_ready,
        input  pc_write, IFID_write, IFID_flush, IDEX_flush, front_hold, MEMWB_bubble,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  IDEX_mem_read, IDEX_rd, IFID_rs1, IFID_rs2, IFID_use_rs1, IFID_use_rs2,
               EX_redirect, dmem_req, dmem_ready,
        output pc_write, IFID_write, IFID_flush, IDEX_flush, front_hold, MEMWB_bubble,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             r,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (r) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/hazard_controller.sv
// Per-cycle advance/hold/flush sequencer for the 5-stage core: load-use
// stalls, data-memory wait states and EX redirects, plus perf counters.
module hazard_controller
    import core_pkg::*;
#(
    parameter int LU_STALLS = 1,
    parameter int CNT_W     = 32
) (
    input logic               clk,
    input logic               r,
    hazard_controller_if.slave hz
);
    localparam logic [2:0] LU_INIT = 3'(LU_STALLS - 1);

    state_e     r_state;
    state_e     r_ret_state;
    logic [2:0] r_lu_cnt;
    logic [2:0] r_ret_lu_cnt;

    logic  w_load_use;
    logic  w_mem_wait;
    logic  w_redirect_taken;
    ctrl_t w_ctrl;

    assign w_load_use = hz.IDEX_mem_read && (hz.IDEX_rd != REG_ZERO) &&
                        ((hz.IFID_use_rs1 && (hz.IDEX_rd == hz.IFID_rs1)) ||
                         (hz.IFID_use_rs2 && (hz.IDEX_rd == hz.IFID_rs2)));
    assign w_mem_wait = hz.dmem_req && !hz.dmem_ready;

    // Priority decode; MWAIT falls through to a plain advance once memory is not stalling.
    always_comb begin
        w_ctrl           = CTRL_RUN;
        w_redirect_taken = 1'b0;
        if (r) begin
            w_ctrl = CTRL_RUN;
        end else if (w_mem_wait) begin
            w_ctrl = CTRL_FREEZE;
        end else if (r_state == ST_MWAIT) begin
            w_ctrl = CTRL_RUN;
        end else if (r_state == ST_LU) begin
            w_ctrl = CTRL_LU;
        end else if (hz.EX_redirect) begin
            w_ctrl           = CTRL_REDIRECT;
            w_redirect_taken = 1'b1;
        end else if (w_load_use) begin
            w_ctrl = CTRL_LU;
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_state      <= ST_RUN;
            r_lu_cnt     <= 3'd0;
            r_ret_state  <= ST_RUN;
            r_ret_lu_cnt <= 3'd0;
        end else if (w_mem_wait) begin
            // Only the state that was interrupted is saved; a longer wait keeps it.
            if (r_state != ST_MWAIT) begin
                r_ret_state  <= r_state;
                r_ret_lu_cnt <= r_lu_cnt;
            end
            r_state <= ST_MWAIT;
        end else begin
            case (r_state)
                ST_MWAIT: begin
                    if (hz.dmem_ready) begin
                        r_state  <= r_ret_state;
                        r_lu_cnt <= r_ret_lu_cnt;
                    end
                end
                ST_LU: begin
                    if (r_lu_cnt <= 3'd1) begin
                        r_state  <= ST_RUN;
                        r_lu_cnt <= 3'd0;
                    end else begin
                        r_lu_cnt <= r_lu_cnt - 3'd1;
                    end
                end
                default: begin
                    if (!hz.EX_redirect && w_load_use && (LU_STALLS > 1)) begin
                        r_state  <= ST_LU;
                        r_lu_cnt <= LU_INIT;
                    end
                end
            endcase
        end
    end

    assign hz.pc_write     = w_ctrl.pc_write;
    assign hz.IFID_write   = w_ctrl.ifid_write;
    assign hz.IFID_flush   = w_ctrl.ifid_flush;
    assign hz.IDEX_flush   = w_ctrl.idex_flush;
    assign hz.front_hold   = w_ctrl.front_hold;
    assign hz.MEMWB_bubble = w_ctrl.memwb_bubble;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .r   (r),
        .inc (!w_ctrl.pc_write),
        .cnt (hz.stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .r   (r),
        .inc (w_redirect_taken),
        .cnt (hz.flush_cnt)
    );
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: two instances (1 and 3 load-use bubbles) driven
// in lockstep, checked against a bubble-count reference model.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       tb_r;
    logic       tb_mr;
    logic [4:0] tb_rd;
    logic [4:0] tb_rs1;
    logic [4:0] tb_rs2;
    logic       tb_u1;
    logic       tb_u2;
    logic       tb_redir;
    logic       tb_req;
    logic       tb_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(32)) hz1 ();
    hazard_controller_if #(.CNT_W(32)) hz3 ();

    assign hz1.IDEX_mem_read = tb_mr;
    assign hz1.IDEX_rd       = tb_rd;
    assign hz1.IFID_rs1      = tb_rs1;
    assign hz1.IFID_rs2      = tb_rs2;
    assign hz1.IFID_use_rs1  = tb_u1;
    assign hz1.IFID_use_rs2  = tb_u2;
    assign hz1.EX_redirect   = tb_redir;
    assign hz1.dmem_req      = tb_req;
    assign hz1.dmem_ready    = tb_rdy;
    assign hz3.IDEX_mem_read = tb_mr;
    assign hz3.IDEX_rd       = tb_rd;
    assign hz3.IFID_rs1      = tb_rs1;
    assign hz3.IFID_rs2      = tb_rs2;
    assign hz3.IFID_use_rs1  = tb_u1;
    assign hz3.IFID_use_rs2  = tb_u2;
    assign hz3.EX_redirect   = tb_redir;
    assign hz3.dmem_req      = tb_req;
    assign hz3.dmem_ready    = tb_rdy;

    hazard_controller #(.LU_STALLS(1), .CNT_W(32)) dut1 (.clk(clk), .r(tb_r), .hz(hz1));
    hazard_controller #(.LU_STALLS(3), .CNT_W(32)) dut3 (.clk(clk), .r(tb_r), .hz(hz3));

    // Reference model: bubbles still owed, memory-wait flag and the bubbles parked during a wait.
    int          lu_cfg   [2] = '{1, 3};
    int          m_left   [2];
    bit          m_wait   [2];
    int          m_saved  [2];
    int unsigned m_stall  [2];
    int unsigned m_flush  [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_load_use();
        return tb_mr && (tb_rd != 5'd0) &&
               ((tb_u1 && tb_rd == tb_rs1) || (tb_u2 && tb_rd == tb_rs2));
    endfunction

    // {pc_write, IFID_write, IFID_flush, IDEX_flush, front_hold, MEMWB_bubble}
    function automatic logic [5:0] model_ctrl(input int k);
        if (tb_r)                        return 6'b110000;
        if (tb_req && !tb_rdy)           return 6'b000011;
        if (m_wait[k])                   return 6'b110000;
        if (m_left[k] > 0)               return 6'b000100;
        if (tb_redir)                    return 6'b111100;
        if (model_load_use())            return 6'b000100;
        return 6'b110000;
    endfunction

    task automatic model_update(input int k, input logic pcw);
        if (tb_r) begin
            m_left[k]  = 0;
            m_wait[k]  = 1'b0;
            m_saved[k] = 0;
            m_stall[k] = 0;
            m_flush[k] = 0;
            return;
        end
        if (!pcw) m_stall[k]++;
        if (tb_req && !tb_rdy) begin
            if (!m_wait[k]) m_saved[k] = m_left[k];
            m_wait[k] = 1'b1;
        end else if (m_wait[k]) begin
            if (tb_rdy) begin
                m_wait[k] = 1'b0;
                m_left[k] = m_saved[k];
            end
        end else if (m_left[k] > 0) begin
            m_left[k]--;
        end else if (tb_redir) begin
            m_flush[k]++;
        end else if (model_load_use()) begin
            m_left[k] = lu_cfg[k] - 1;
        end
    endtask

    function automatic logic [5:0] dut_ctrl(input int k);
        if (k == 0)
            return {hz1.pc_write, hz1.IFID_write, hz1.IFID_flush, hz1.IDEX_flush,
                    hz1.front_hold, hz1.MEMWB_bubble};
        return {hz3.pc_write, hz3.IFID_write, hz3.IFID_flush, hz3.IDEX_flush,
                hz3.front_hold, hz3.MEMWB_bubble};
    endfunction

    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic redir, input logic req, input logic rdy, input logic rst);
        logic [5:0] exp_ctrl;
        tb_mr = mr; tb_rd = rd; tb_rs1 = rs1; tb_rs2 = rs2; tb_u1 = u1; tb_u2 = u2;
        tb_redir = redir; tb_req = req; tb_rdy = rdy; tb_r = rst;
        #2;
        for (int k = 0; k < 2; k++) begin
            exp_ctrl = model_ctrl(k);
            check_eq($sformatf("ctrl_lu%0d", lu_cfg[k]), dut_ctrl(k), exp_ctrl);
            model_update(k, exp_ctrl[5]);
        end
        @(posedge clk);
        #1;
        check_eq("stall_cnt_lu1", hz1.stall_cnt, m_stall[0]);
        check_eq("flush_cnt_lu1", hz1.flush_cnt, m_flush[0]);
        check_eq("stall_cnt_lu3", hz3.stall_cnt, m_stall[1]);
        check_eq("flush_cnt_lu3", hz3.flush_cnt, m_flush[1]);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic lu_pair(input logic redir);
        step(1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, redir, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_wait[k] = 1'b0; m_saved[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        tb_r = 1'b1; tb_mr = 1'b0; tb_rd = '0; tb_rs1 = '0; tb_rs2 = '0;
        tb_u1 = 1'b0; tb_u2 = 1'b0; tb_redir = 1'b0; tb_req = 1'b0; tb_rdy = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        check_eq("reset_stall", hz3.stall_cnt, 32'd0);
        check_eq("reset_pc_write", {31'd0, hz3.pc_write}, 32'd1);

        // Single load-use hazard: one bubble vs three bubbles
        do_reset();
        lu_pair(1'b0);
        repeat (3) idle();
        check_eq("lu1_stall_total", hz1.stall_cnt, 32'd1);
        check_eq("lu3_stall_total", hz3.stall_cnt, 32'd3);

        // x0 destination and unused rs2 never stall
        do_reset();
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("no_hazard_stall", hz3.stall_cnt, 32'd0);

        // Redirect beats load-use
        do_reset();
        lu_pair(1'b1);
        repeat (3) idle();
        check_eq("redir_flush", hz3.flush_cnt, 32'd1);
        check_eq("redir_stall", hz3.stall_cnt, 32'd0);

        // Memory wait in the middle of a load-use stall
        do_reset();
        lu_pair(1'b0);
        repeat (4) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) idle();
        check_eq("mwait_stall_lu3", hz3.stall_cnt, 32'd7);
        check_eq("mwait_stall_lu1", hz1.stall_cnt, 32'd5);

        // Reset in the second LU cycle abandons the stall
        do_reset();
        lu_pair(1'b0);
        idle();
        do_reset();
        check_eq("midstall_reset_cnt", hz3.stall_cnt, 32'd0);
        idle();
        check_eq("midstall_reset_pcw", {31'd0, hz3.pc_write}, 32'd1);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
